// File: rtl/uart_rx_engine.sv
// Parametrised UART receiver: synchronised, majority-voted line sampling,
// frame/parity/break/overrun detection and a small valid/ready receive FIFO.
module uart_rx_engine #(
   parameter int CLOCK_FREQ  = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int MSB_FIRST   = 0,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_break,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF       = BIT_PERIOD / 2;
   localparam int TW         = $clog2(BIT_PERIOD);
   localparam int BCW        = $clog2(DATA_BITS);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int EW         = DATA_BITS + 3;

   localparam logic [TW-1:0]  T_LO      = TW'(HALF - 1);
   localparam logic [TW-1:0]  T_MID     = TW'(HALF);
   localparam logic [TW-1:0]  T_HI      = TW'(HALF + 1);
   localparam logic [TW-1:0]  T_WRAP    = TW'(BIT_PERIOD - 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
   localparam logic           LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   localparam state_t AFTER_DATA = (PARITY != 0) ? S_PARITY : S_STOP;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_sync;
   logic                   rxd_prev;
   state_t                 state;
   logic [TW-1:0]          timer;
   logic                   samp_a;
   logic                   samp_b;
   logic [DATA_BITS-1:0]   shreg;
   logic [BCW-1:0]         bit_cnt;
   logic                   par_bit;
   logic                   stop_cnt;
   logic                   stop_err;
   logic                   push_req;
   logic [EW-1:0]          push_entry;

   logic at_lo, at_mid, at_hi, at_wrap;
   logic maj;
   logic ferr_now, perr_now, brk_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      end
   end

   assign rxd_sync = sync_q[SYNC_STAGES-1];

   assign at_lo   = (timer == T_LO);
   assign at_mid  = (timer == T_MID);
   assign at_hi   = (timer == T_HI);
   assign at_wrap = (timer == T_WRAP);

   // The third sample is the live synced value, so the vote resolves at H+1.
   assign maj = (samp_a & samp_b) | (samp_a & rxd_sync) | (samp_b & rxd_sync);

   always_comb begin
      perr_now = 1'b0;
      if (PARITY == 1) begin
         perr_now = ~(^shreg ^ par_bit);
      end else if (PARITY == 2) begin
         perr_now = ^shreg ^ par_bit;
      end
      ferr_now = stop_err | ~maj;
      brk_now  = ferr_now & (shreg == '0) & ~par_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         timer      <= '0;
         rxd_prev   <= 1'b1;
         samp_a     <= 1'b1;
         samp_b     <= 1'b1;
         shreg      <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         stop_cnt   <= 1'b0;
         stop_err   <= 1'b0;
         push_req   <= 1'b0;
         push_entry <= '0;
      end else begin
         rxd_prev <= rxd_sync;
         push_req <= 1'b0;
         if (at_lo) samp_a <= rxd_sync;
         if (at_mid) samp_b <= rxd_sync;
         timer <= at_wrap ? '0 : timer + 1'b1;
         case (state)
            S_IDLE: begin
               timer <= '0;
               if (rxd_prev && !rxd_sync) state <= S_START;
            end
            S_START: begin
               if (at_hi && maj) begin
                  state <= S_IDLE;
                  timer <= '0;
               end else if (at_wrap) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               if (at_hi) begin
                  if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], maj};
                  else                shreg <= {maj, shreg[DATA_BITS-1:1]};
               end
               if (at_wrap && bit_cnt == LAST_BIT) begin
                  state    <= AFTER_DATA;
                  stop_cnt <= 1'b0;
                  stop_err <= 1'b0;
               end else if (at_wrap) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (at_hi) par_bit <= maj;
               if (at_wrap) begin
                  state    <= S_STOP;
                  stop_cnt <= 1'b0;
                  stop_err <= 1'b0;
               end
            end
            S_STOP: begin
               // Decide mid-way through the last stop bit so a new start edge can follow.
               if (at_hi) begin
                  if (stop_cnt == LAST_STOP) begin
                     push_req   <= 1'b1;
                     push_entry <= {shreg, ferr_now, perr_now, brk_now};
                     state      <= ferr_now ? S_WAIT_IDLE : S_IDLE;
                     timer      <= '0;
                  end else begin
                     stop_err <= ferr_now;
                  end
               end else if (at_wrap) begin
                  stop_cnt <= 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               timer <= '0;
               if (rxd_sync) state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   assign rx_busy = (state != S_IDLE);

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          do_push;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign pop     = rx_valid & rx_ready;
   assign do_push = push_req & (~full | pop);

   // A push into a full FIFO only succeeds when the head leaves in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rx_overrun <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         rx_overrun <= push_req & full & ~pop;
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop) count <= count + 1'b1;
         else if (!do_push && pop) count <= count - 1'b1;
      end
   end

   assign rx_valid = (count != '0);
   assign {rx_data, rx_frame_err, rx_parity_err, rx_break} = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench: an 8N1 receiver and a 7E2 receiver driven with serialised
// frames; expected entries are queued at stimulus time and popped by monitors.
module tb_uart_rx_engine;

   localparam int BP = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       rxd_a, rxd_b;
   logic       rx_ready_a, rx_ready_b;
   logic       rx_valid_a, rx_valid_b;
   logic [7:0] rx_data_a;
   logic [6:0] rx_data_b;
   logic       ferr_a, perr_a, brk_a, ovr_pulse_a, busy_a;
   logic       ferr_b, perr_b, brk_b, ovr_pulse_b, busy_b;

   uart_rx_engine #(
      .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
      .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4), .SYNC_STAGES(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_valid(rx_valid_a),
      .rx_ready(rx_ready_a), .rx_data(rx_data_a), .rx_frame_err(ferr_a),
      .rx_parity_err(perr_a), .rx_break(brk_a), .rx_overrun(ovr_pulse_a),
      .rx_busy(busy_a)
   );

   uart_rx_engine #(
      .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
      .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(4), .SYNC_STAGES(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_valid(rx_valid_b),
      .rx_ready(rx_ready_b), .rx_data(rx_data_b), .rx_frame_err(ferr_b),
      .rx_parity_err(perr_b), .rx_break(brk_b), .rx_overrun(ovr_pulse_b),
      .rx_busy(busy_b)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int popped_a = 0;
   int popped_b = 0;
   int ovr_a    = 0;
   int ovr_b    = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ovr_pulse_a) ovr_a++;
         if (rx_valid_a && rx_ready_a) begin
            popped_a++;
            if (qa.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL a_unexpected_entry got=%h expected=none",
                        {5'd0, rx_data_a, ferr_a, perr_a, brk_a});
            end else begin
               check_output("a_entry", {5'd0, rx_data_a, ferr_a, perr_a, brk_a}, qa.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ovr_pulse_b) ovr_b++;
         if (rx_valid_b && rx_ready_b) begin
            popped_b++;
            if (qb.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL b_unexpected_entry got=%h expected=none",
                        {6'd0, rx_data_b, ferr_b, perr_b, brk_b});
            end else begin
               check_output("b_entry", {6'd0, rx_data_b, ferr_b, perr_b, brk_b}, qb.pop_front());
            end
         end
      end
   end

   task automatic wait_clks(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // 8N1 frame on line A; optional one-clock inverted spike inside one data bit.
   task automatic apply_frame_a(input logic [7:0] d, input logic stop, input logic chk_busy,
                                input int spike_bit, input int spike_pos, input logic expect_entry);
      if (expect_entry) qa.push_back({5'd0, d, ~stop, 1'b0, ~stop & (d == 8'h00)});
      rxd_a = 1'b0;
      wait_clks(BP);
      for (int i = 0; i < 8; i++) begin
         rxd_a = d[i];
         if (i == spike_bit) begin
            wait_clks(spike_pos);
            rxd_a = ~d[i];
            wait_clks(1);
            rxd_a = d[i];
            wait_clks(BP - 1 - spike_pos);
         end else begin
            wait_clks(BP);
         end
         if (chk_busy && i == 3) check_output("a_busy_mid_frame", {15'd0, busy_a}, 16'd1);
      end
      rxd_a = stop;
      wait_clks(BP);
      if (!stop) begin
         rxd_a = 1'b1;
         wait_clks(2 * BP);
      end
   endtask

   // 7E2 frame on line B; the parity bit can be flipped and the second stop bit driven low.
   task automatic apply_frame_b(input logic [6:0] d, input logic flip, input logic stop2);
      logic p;
      p = (^d) ^ flip;
      qb.push_back({6'd0, d, ~stop2, flip, ~stop2 & (d == 7'h00) & ~p});
      rxd_b = 1'b0;
      wait_clks(BP);
      for (int i = 0; i < 7; i++) begin
         rxd_b = d[i];
         wait_clks(BP);
      end
      rxd_b = p;
      wait_clks(BP);
      rxd_b = 1'b1;
      wait_clks(BP);
      rxd_b = stop2;
      wait_clks(BP);
      if (!stop2) begin
         rxd_b = 1'b1;
         wait_clks(2 * BP);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < 50 * BP) begin
         wait_clks(1);
         t++;
      end
      check_output({name, "_left_a"}, 16'(qa.size()), 16'd0);
      check_output({name, "_left_b"}, 16'(qb.size()), 16'd0);
   endtask

   int base;

   initial begin
      rst_n      = 1'b0;
      rxd_a      = 1'b1;
      rxd_b      = 1'b1;
      rx_ready_a = 1'b1;
      rx_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_valid_a", {15'd0, rx_valid_a}, 16'd0);
      check_output("reset_busy_a", {15'd0, busy_a}, 16'd0);
      check_output("reset_data_flags_a", {5'd0, rx_data_a, ferr_a, perr_a, brk_a}, 16'd0);
      check_output("reset_overrun_a", {15'd0, ovr_pulse_a}, 16'd0);
      check_output("reset_valid_b", {15'd0, rx_valid_b}, 16'd0);
      rst_n = 1'b1;
      wait_clks(4);

      apply_frame_a(8'hA5, 1'b1, 1'b1, -1, 0, 1'b1);
      apply_frame_b(7'h41, 1'b0, 1'b1);
      apply_frame_b(7'h41, 1'b1, 1'b1);
      apply_frame_b(7'h41, 1'b0, 1'b0);
      wait_drain("basic");

      base = popped_a;
      rxd_a = 1'b0;
      wait_clks(6);
      rxd_a = 1'b1;
      wait_clks(3 * BP);
      check_output("glitch_busy", {15'd0, busy_a}, 16'd0);
      check_output("glitch_no_entry", 16'(popped_a - base), 16'd0);

      for (int k = 0; k < 4; k++)
         apply_frame_a(8'($urandom), 1'b1, 1'b0, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 14)), 1'b1);
      wait_drain("spike");

      base = popped_a;
      qa.push_back({5'd0, 8'h00, 1'b1, 1'b0, 1'b1});
      rxd_a = 1'b0;
      wait_clks(30 * BP);
      rxd_a = 1'b1;
      wait_clks(2 * BP);
      apply_frame_a(8'h3C, 1'b1, 1'b0, -1, 0, 1'b1);
      wait_drain("break");
      check_output("break_entry_count", 16'(popped_a - base), 16'd2);

      fork
         begin
            for (int k = 0; k < 8; k++)
               apply_frame_a(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, -1, 0, 1'b1);
         end
         begin
            for (int k = 0; k < 6; k++)
               apply_frame_b(7'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
         end
      join
      wait_drain("random");

      rx_ready_a = 1'b0;
      base = ovr_a;
      for (int k = 1; k <= 5; k++)
         apply_frame_a(8'(k), 1'b1, 1'b0, -1, 0, (k <= 4));
      wait_clks(2 * BP);
      check_output("overrun_pulses", 16'(ovr_a - base), 16'd1);
      check_output("overrun_valid_held", {15'd0, rx_valid_a}, 16'd1);
      check_output("overrun_head_stable", {5'd0, rx_data_a, ferr_a, perr_a, brk_a}, qa[0]);
      rx_ready_a = 1'b1;
      wait_drain("overrun");

      rxd_a = 1'b0;
      wait_clks(BP);
      rxd_a = 1'b1;
      wait_clks(BP);
      rxd_a = 1'b0;
      wait_clks(5);
      rst_n = 1'b0;
      #1;
      check_output("midreset_valid", {15'd0, rx_valid_a}, 16'd0);
      check_output("midreset_busy", {15'd0, busy_a}, 16'd0);
      check_output("midreset_data", {8'd0, rx_data_a}, 16'd0);
      rxd_a = 1'b1;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(2 * BP);
      base = popped_a;
      apply_frame_a(8'h5A, 1'b1, 1'b0, -1, 0, 1'b1);
      wait_drain("after_reset");
      check_output("after_reset_entry_count", 16'(popped_a - base), 16'd1);
      check_output("overrun_b_none", 16'(ovr_b), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 input controller feeding the I/O subsystem.
- Adds:
  - configurable data width, parity, stop bits and bit order
  - rxd metastability synchroniser
  - 3-sample majority voting
  - false-start rejection
  - framing, parity, break and overrun detection
  - small receive FIFO with valid/ready output, replacing the one-cycle trigger.
- Sits between the board RXD pin and the core's I/O bus.

Parameters:
- CLOCK_FREQ, 100000000, system clock in Hz.
- BAUD_RATE, 115200, line rate; BIT_PERIOD = CLOCK_FREQ/BAUD_RATE (localparam, must be >= 8).
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- MSB_FIRST, 0, 0 = LSB first on the line (standard), 1 = MSB first.
- FIFO_DEPTH, 4, entries, power of two, >= 2.
- SYNC_STAGES, 2, rxd synchroniser flops, >= 2.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  serial line, idle high, asynchronous to clk
- rx_valid  out  1  FIFO head holds a frame
- rx_ready  in  1  consumer accepts head when rx_valid & rx_ready
- rx_data  out  DATA_BITS  head data, bit 0 = first-received bit unless MSB_FIRST
- rx_frame_err  out  1  head frame had a low stop bit
- rx_parity_err  out  1  head frame parity mismatch (always 0 when PARITY = 0)
- rx_break  out  1  head frame all-zero data with low stop bit
- rx_overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full
- rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops = 1, FSM = IDLE, timer = 0, FIFO empty.
  - Outputs: rx_valid = 0, rx_data = 0, all flags = 0, rx_overrun = 0, rx_busy = 0.
  - A mid-frame reset abandons the frame; no partial entry is ever pushed.
- Timer:
  - counts 0..BIT_PERIOD-1 and wraps; restarted to 0 on each state entry.
  - Samples are taken at counts H-1, H and H+1, where H = BIT_PERIOD/2 (integer division).
  - Bit value = majority of the 3 samples.
  - Bit boundary = timer wrap.
- FSM states:
  - IDLE: synced rxd 1->0 edge -> START.
  - START: at H+1, majority 1 -> IDLE (false start, nothing pushed); otherwise at wrap -> DATA.
  - DATA: shifts DATA_BITS majority bits; after the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: compares the sampled bit with the computed parity.
    - odd: XOR of data and parity bit must be 1.
    - even: XOR must be 0.
  - STOP: samples STOP_BITS stop bits; frame_err = any stop sample majority 0.
    - Decision at H+1 of the last stop bit; no wait for its end, so back-to-back frames are allowed.
    - frame_err = 0 -> IDLE.
    - frame_err = 1 -> WAIT_IDLE.
  - WAIT_IDLE: waits for synced rxd = 1 -> IDLE. This prevents a held-low break from generating repeated frames.
- Break: break = frame_err & (data == 0) & (parity bit == 0 when present).
- Push:
  - Happens in the cycle after the final stop decision.
  - rx_valid rises on the next cycle when the FIFO was empty.
  - rxd-to-FSM latency is SYNC_STAGES cycles.
- FIFO:
  - Entry = {data, frame_err, parity_err, break}.
  - Outputs are driven directly from head storage; they hold stable while rx_valid & !rx_ready.
  - Pop on rx_valid & rx_ready.
  - Push when full without pop: frame dropped, rx_overrun = 1 for exactly one cycle, FIFO unchanged.
  - Push when full with simultaneous pop: both happen; no overrun.
  - Push and pop when non-empty: count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; a separate count of log2(FIFO_DEPTH)+1 bits gives full/empty.
  - rx_data and flags are don't-care while rx_valid = 0 and are not checked.
- rx_ready is ignored while rx_valid = 0.

Test Plan:
- Config: CLOCK_FREQ = 1600000, BAUD_RATE = 100000 (BIT_PERIOD = 16), rx_ready = 1. Stimulus: 8N1 byte 0xA5 -> one rx_valid cycle, rx_data = 0xA5, all flags 0, rx_busy high during the frame.
- Config: PARITY = 2, DATA_BITS = 7, STOP_BITS = 2. Stimulus: 0x41 with correct parity, then 0x41 with flipped parity bit -> entries {0x41, perr = 0} then {0x41, perr = 1}.
- Stimulus: 0.4-bit low glitch on idle line -> no entry; FSM returns to IDLE. Stimulus: a single 1-clock spike inside a data bit -> majority ignores it, byte correct.
- Stimulus: rxd held low 3 frame times, then high -> exactly one entry: data = 0x00, frame_err = 1, break = 1; next byte 0x3C decodes correctly.
- Config: FIFO_DEPTH = 4, rx_ready = 0. Stimulus: 5 back-to-back bytes 0x01..0x05 -> rx_overrun pulses once on the 5th; draining yields 0x01..0x04 in order.
- Stimulus: rst_n asserted mid-data-bit of a frame -> outputs 0 immediately; after release, no entry from the partial frame; next full byte 0x5A received correctly.
